byte_lane_memory: RTL and testbench



---
 rtl/byte_lane_memory.sv | 162 ++++++++++++++++
 tb/tb_byte_lane_memory.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/byte_lane_memory.sv
// Byte-lane-banked data memory for the load/store path: one 8-bit RAM per lane,
// lane rotation for misaligned accesses, sign/zero extension and write-through MMIO registers.
module byte_lane_memory #(
  parameter int          XLEN             = 32,
  parameter int          ADDR_WIDTH       = 11,
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int          NUM_MMIO         = 1,
  parameter logic [31:0] MMIO_BASE        = 32'h7F0,
  parameter bit          INVERT_MMIO      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [31:0]              req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     rsp_valid,
  output logic [XLEN-1:0]          rsp_rdata,
  output logic                     rsp_fault,
  output logic [NUM_MMIO*XLEN-1:0] mmio_out
);

  localparam int BYTES = XLEN / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int IW    = ADDR_WIDTH - LB;
  localparam int DEPTH = 1 << IW;

  logic            accept;
  logic [IW-1:0]   idx;
  logic [LB-1:0]   off;
  logic [LB-1:0]   rel;
  logic [3:0]      n_bytes;
  logic            fault;
  logic [31:0]     word_addr;
  logic [BYTES-1:0] lane_mask;
  logic [BYTES-1:0] lane_we;
  logic [IW-1:0]   lane_addr  [BYTES];
  logic [7:0]      lane_wdata [BYTES];
  logic [XLEN-1:0] rd_word;

  // Request decode: lane k carries request byte (k - off) mod BYTES; lanes below off spill into the next word.
  always_comb begin
    accept    = req_valid & clk_enable;
    idx       = req_addr[ADDR_WIDTH-1:LB];
    off       = req_addr[LB-1:0];
    n_bytes   = 4'd1 << req_size;
    fault     = (32'(n_bytes) > BYTES) ||
                (!ALLOW_MISALIGNED && ((req_addr & (32'(n_bytes) - 32'd1)) != 32'd0));
    word_addr = {req_addr[31:LB], {LB{1'b0}}};
    rel       = '0;
    for (int k = 0; k < BYTES; k++) begin
      rel           = LB'(k) - off;
      lane_mask[k]  = 4'(rel) < n_bytes;
      lane_wdata[k] = req_wdata[{rel, 3'b000} +: 8];
      lane_addr[k]  = (LB'(k) < off) ? idx + IW'(1) : idx;
      lane_we[k]    = accept & req_we & ~fault & lane_mask[k];
    end
  end

  for (genvar k = 0; k < BYTES; k++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (lane_we[k]) mem[lane_addr[k]] <= lane_wdata[k];
      if (accept)     rd_q <= mem[lane_addr[k]];
    end
    assign rd_word[k*8 +: 8] = rd_q;
  end

  logic [XLEN-1:0] mmio_d [NUM_MMIO];
  logic [XLEN-1:0] mmio_q [NUM_MMIO];
  logic [31:0]     reg_addr;

  always_comb begin
    reg_addr = '0;
    for (int i = 0; i < NUM_MMIO; i++) begin
      mmio_d[i] = mmio_q[i];
      reg_addr  = MMIO_BASE + 32'(i * BYTES);
      for (int k = 0; k < BYTES; k++) begin
        if (lane_we[k] && ((LB'(k) >= off) ? (word_addr == reg_addr)
                                           : (word_addr + 32'(BYTES) == reg_addr)))
          mmio_d[i][k*8 +: 8] = lane_wdata[k];
      end
    end
  end

  logic          rsp_valid_d, rsp_valid_q;
  logic          rsp_fault_d, rsp_fault_q;
  logic          load_ok_d, load_ok_q;
  logic          signed_d, signed_q;
  logic [LB-1:0] off_d, off_q;
  logic [3:0]    n_d, n_q;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    load_ok_d   = load_ok_q;
    signed_d    = signed_q;
    off_d       = off_q;
    n_d         = n_q;
    if (clk_enable) begin
      rsp_valid_d = req_valid;
      rsp_fault_d = req_valid & fault;
      load_ok_d   = req_valid & ~req_we & ~fault;
      signed_d    = req_signed;
      off_d       = off;
      n_d         = n_bytes;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      load_ok_q   <= 1'b0;
      signed_q    <= 1'b0;
      off_q       <= '0;
      n_q         <= '0;
      for (int i = 0; i < NUM_MMIO; i++) mmio_q[i] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      load_ok_q   <= load_ok_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      n_q         <= n_d;
      for (int i = 0; i < NUM_MMIO; i++) mmio_q[i] <= mmio_d[i];
    end
  end

  // Response stage: undo the lane rotation, then extend above the access size.
  logic [XLEN-1:0] rot;
  logic [XLEN-1:0] ext;
  logic [LB-1:0]   src;
  logic            sign_bit;

  always_comb begin
    src      = '0;
    sign_bit = 1'b0;
    for (int j = 0; j < BYTES; j++) begin
      src            = LB'(j) + off_q;
      rot[j*8 +: 8]  = rd_word[{src, 3'b000} +: 8];
    end
    for (int j = 0; j < BYTES; j++)
      if (4'(j) == n_q - 4'd1) sign_bit = rot[j*8+7];
    ext = rot;
    for (int j = 0; j < BYTES; j++)
      if (4'(j) >= n_q) ext[j*8 +: 8] = (signed_q & sign_bit) ? 8'hFF : 8'h00;
    rsp_rdata = load_ok_q ? ext : '0;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;

  for (genvar i = 0; i < NUM_MMIO; i++) begin : g_mmio
    assign mmio_out[i*XLEN +: XLEN] = INVERT_MMIO ? ~mmio_q[i] : mmio_q[i];
  end

endmodule

// File: tb/tb_byte_lane_memory.sv
// Directed bench for byte_lane_memory: one misalignment-tolerant instance and one
// aligned-only instance driven by the same request stream.
module tb_byte_lane_memory;

  logic        clk = 1'b0;
  logic        rst, clk_enable, req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault, na_valid, na_fault;
  logic [31:0] rsp_rdata, mmio_out, na_rdata, na_mmio;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  byte_lane_memory dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .req_valid(req_valid),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .mmio_out(mmio_out)
  );

  byte_lane_memory #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .req_valid(req_valid),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(na_valid),
    .rsp_rdata(na_rdata), .rsp_fault(na_fault), .mmio_out(na_mmio)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request, lets it be accepted, and returns 1 time unit after the edge.
  task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_enable = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_fault", rsp_fault, 0);
    chk("reset_mmio",  mmio_out, 32'hFFFF_FFFF);

    access(1, 2, 0, 32'h100, 32'hDEAD_BEEF);
    chk("sw_valid", rsp_valid, 1);
    chk("sw_rdata", rsp_rdata, 0);
    chk("sw_fault", rsp_fault, 0);
    access(0, 2, 0, 32'h100, 0);
    chk("lw_valid", rsp_valid, 1);
    chk("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("lw_fault", rsp_fault, 0);

    access(1, 2, 0, 32'h100, 32'h1122_3344);
    access(1, 2, 0, 32'h104, 32'h5566_7788);
    access(0, 2, 0, 32'h102, 0);
    chk("lw_mis_rdata", rsp_rdata, 32'h7788_1122);
    chk("lw_mis_fault", rsp_fault, 0);
    chk("na_lw_mis_fault", na_fault, 1);
    chk("na_lw_mis_rdata", na_rdata, 0);
    access(0, 1, 0, 32'h105, 0);
    chk("lhu_mis", rsp_rdata, 32'h0000_6677);
    chk("na_lhu_mis_fault", na_fault, 1);
    access(0, 0, 1, 32'h103, 0);
    chk("lb_pos", rsp_rdata, 32'h0000_0011);
    access(0, 0, 1, 32'h104, 0);
    chk("lb_neg", rsp_rdata, 32'hFFFF_FF88);
    chk("na_lb_neg", na_rdata, 32'hFFFF_FF88);
    access(0, 0, 0, 32'h104, 0);
    chk("lbu", rsp_rdata, 32'h0000_0088);

    access(1, 2, 0, 32'h7FE, 32'hA1B2_C3D4);
    access(0, 2, 0, 32'h000, 0);
    chk("wrap_low_half", rsp_rdata[15:0], 16'hA1B2);
    access(0, 1, 0, 32'h7FE, 0);
    chk("wrap_lhu", rsp_rdata, 32'h0000_C3D4);

    access(1, 1, 0, 32'h7F0, 32'h0000_1234);
    chk("mmio_sh", mmio_out, 32'hFFFF_EDCB);
    access(1, 0, 0, 32'h7F3, 32'h0000_00FF);
    chk("mmio_sb", mmio_out, 32'h00FF_EDCB);
    chk("na_mmio_sb", na_mmio, 32'h00FF_EDCB);

    access(1, 2, 0, 32'h102, 32'h0000_0001);
    chk("na_sw_mis_valid", na_valid, 1);
    chk("na_sw_mis_fault", na_fault, 1);
    chk("na_sw_mis_rdata", na_rdata, 0);
    chk("sw_mis_fault", rsp_fault, 0);
    access(0, 2, 0, 32'h100, 0);
    chk("na_lw_unchanged", na_rdata, 32'h1122_3344);
    chk("lw_after_mis_sw", rsp_rdata, 32'h0001_3344);
    access(0, 3, 0, 32'h000, 0);
    chk("double_fault", rsp_fault, 1);
    chk("double_rdata", rsp_rdata, 0);

    // Stall: a store to the MMIO word held for three cycles must change nothing.
    access(0, 1, 0, 32'h7F0, 0);
    chk("pre_stall_lhu", rsp_rdata, 32'h0000_1234);
    clk_enable = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h7F0; req_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 32'h0000_1234);
    end
    chk("stall_mmio", mmio_out, 32'h00FF_EDCB);
    clk_enable = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", rsp_valid, 0);
    access(0, 1, 0, 32'h7F0, 0);
    chk("post_stall_lhu", rsp_rdata, 32'h0000_1234);

    // Asynchronous reset between accept and response drops the response.
    access(0, 2, 0, 32'h100, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_mmio",  mmio_out, 32'hFFFF_FFFF);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
